// File: rtl/machine_ctrl.sv
// rtl/machine_ctrl.sv - 8-slot instruction-cycle sequencer for the 8-instruction RISC CPU
//
// Purpose: Steps through 8 slots per instruction: fetch the two IR bytes, decode, then execute.
//          Every control output is registered. The vector for slot k is computed while
//          state == k and captured on that edge, so it appears during the following clock.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   ena          in   run enable; low parks the sequencer at slot 0 with all controls low
//   opcode[2:0]  in   IR[15:13], valid from slot 2 onward
//   zero         in   alu zero flag, sampled in slots 5 and 7 only
//   state[2:0]   out  current slot (0..7)
//   inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, alu_ena, halt
//                out  registered control strobes
module machine_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic [2:0] state,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       load_ir,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       alu_ena,
  output logic       halt
);

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  logic [2:0] state_q, state_d;
  logic inc_pc_q, inc_pc_d;
  logic load_pc_q, load_pc_d;
  logic load_acc_q, load_acc_d;
  logic load_ir_q, load_ir_d;
  logic rd_q, rd_d;
  logic wr_q, wr_d;
  logic datactl_ena_q, datactl_ena_d;
  logic alu_ena_q, alu_ena_d;
  logic halt_q, halt_d;

  always_comb begin
    state_d       = 3'd0;
    inc_pc_d      = 1'b0;
    load_pc_d     = 1'b0;
    load_acc_d    = 1'b0;
    load_ir_d     = 1'b0;
    rd_d          = 1'b0;
    wr_d          = 1'b0;
    datactl_ena_d = 1'b0;
    alu_ena_d     = 1'b0;
    halt_d        = 1'b0;
    if (ena) begin
      state_d = state_q + 3'd1;
      // Opcode decoding uses case with an empty default, so an unknown
      // opcode falls through with every execute-phase strobe held low.
      case (state_q)
        3'd0: begin
          rd_d      = 1'b1;
          load_ir_d = 1'b1;
        end
        3'd1: begin
          rd_d      = 1'b1;
          load_ir_d = 1'b1;
          inc_pc_d  = 1'b1;
        end
        3'd2: begin
        end
        3'd3: begin
          inc_pc_d = 1'b1;
          case (opcode)
            HLT:     halt_d = 1'b1;
            default: ;
          endcase
        end
        3'd4: begin
          case (opcode)
            ADD, AND, XOR, LDA: begin
              rd_d      = 1'b1;
              alu_ena_d = 1'b1;
            end
            JMP:     load_pc_d     = 1'b1;
            STO:     datactl_ena_d = 1'b1;
            default: ;
          endcase
        end
        3'd5: begin
          case (opcode)
            ADD, AND, XOR, LDA: rd_d = 1'b1;
            SKZ:     inc_pc_d = zero;
            JMP: begin
              load_pc_d = 1'b1;
              inc_pc_d  = 1'b1;
            end
            STO:     datactl_ena_d = 1'b1;
            default: ;
          endcase
        end
        3'd6: begin
          case (opcode)
            ADD, AND, XOR, LDA: begin
              rd_d       = 1'b1;
              load_acc_d = 1'b1;
            end
            STO: begin
              wr_d          = 1'b1;
              datactl_ena_d = 1'b1;
            end
            default: ;
          endcase
        end
        3'd7: begin
          // Second half of the skip: two extra PC increments jump over one 2-byte instruction.
          case (opcode)
            SKZ:     inc_pc_d = zero;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= 3'd0;
      inc_pc_q      <= 1'b0;
      load_pc_q     <= 1'b0;
      load_acc_q    <= 1'b0;
      load_ir_q     <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      datactl_ena_q <= 1'b0;
      alu_ena_q     <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      inc_pc_q      <= inc_pc_d;
      load_pc_q     <= load_pc_d;
      load_acc_q    <= load_acc_d;
      load_ir_q     <= load_ir_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      datactl_ena_q <= datactl_ena_d;
      alu_ena_q     <= alu_ena_d;
      halt_q        <= halt_d;
    end
  end

  assign state       = state_q;
  assign inc_pc      = inc_pc_q;
  assign load_pc     = load_pc_q;
  assign load_acc    = load_acc_q;
  assign load_ir     = load_ir_q;
  assign rd          = rd_q;
  assign wr          = wr_q;
  assign datactl_ena = datactl_ena_q;
  assign alu_ena     = alu_ena_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_machine_ctrl.sv
// tb/tb_machine_ctrl.sv - self-checking bench for machine_ctrl
module tb_machine_ctrl;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  // Control vector bit positions
  localparam int B_INC = 8, B_LPC = 7, B_LACC = 6, B_LIR = 5, B_RD = 4;
  localparam int B_WR = 3, B_DAT = 2, B_ALU = 1, B_HLT = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic zero = 1'b0;
  logic [2:0] state;
  logic inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, alu_ena, halt;

  int total = 0;
  int bad = 0;
  bit run_cmp = 1'b0;

  machine_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .state(state), .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
    .load_ir(load_ir), .rd(rd), .wr(wr), .datactl_ena(datactl_ena),
    .alu_ena(alu_ena), .halt(halt)
  );

  always #5 clk = ~clk;

  logic [8:0] dut_vec;
  assign dut_vec = {inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, alu_ena, halt};

  // Reference: which strobes belong to slot k, stated as set membership.
  function automatic logic [8:0] exp_vec(int k, logic [2:0] op, logic z);
    logic [8:0] v;
    bit aluop, fetch;
    aluop = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    fetch = (k == 0) || (k == 1);
    v = '0;
    v[B_RD]   = fetch || (aluop && k >= 4 && k <= 6);
    v[B_LIR]  = fetch;
    v[B_INC]  = (k == 1) || (k == 3) || (op == JMP && k == 5) ||
                (op == SKZ && z && (k == 5 || k == 7));
    v[B_LPC]  = (op == JMP) && (k == 4 || k == 5);
    v[B_LACC] = aluop && k == 6;
    v[B_WR]   = (op == STO) && k == 6;
    v[B_DAT]  = (op == STO) && k >= 4 && k <= 6;
    v[B_ALU]  = aluop && k == 4;
    v[B_HLT]  = (op == HLT) && k == 3;
    return v;
  endfunction

  int m_slot = 0;
  logic [8:0] m_vec = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slot <= 0;
      m_vec  <= '0;
    end else if (ena) begin
      m_vec  <= exp_vec(m_slot, opcode, zero);
      m_slot <= (m_slot + 1) % 8;
    end else begin
      m_slot <= 0;
      m_vec  <= '0;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      total++;
      if (int'(state) != m_slot || dut_vec !== m_vec) begin
        bad++;
        $display("FAIL cycle_cmp: state=%0d vec=%b required state=%0d vec=%b",
                 state, dut_vec, m_slot, m_vec);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s);
    int guard;
    guard = 0;
    while (state != s && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("wait_state_timeout", 32'(state), 32'(s));
  endtask

  logic [8:0] sv [8];

  // Capture one full instruction cycle, indexed by the slot each vector belongs to.
  task automatic collect(input logic [2:0] op, input logic z);
    @(negedge clk);
    opcode = op;
    zero   = z;
    ena    = 1'b1;
    wait_state(3'd1);
    for (int i = 0; i < 8; i++) begin
      sv[(int'(state) + 7) % 8] = dut_vec;
      if (i < 7) @(negedge clk);
    end
  endtask

  function automatic logic [7:0] mask(int b);
    logic [7:0] m;
    for (int s = 0; s < 8; s++) m[s] = sv[s][b];
    return m;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", 32'({state, dut_vec}), 32'd0);
    rst = 1'b0;
    run_cmp = 1'b1;

    collect(LDA, 1'b0);
    check("lda_alu_ena", 32'(mask(B_ALU)), 32'h10);
    check("lda_load_acc", 32'(mask(B_LACC)), 32'h40);
    check("lda_inc_pc", 32'(mask(B_INC)), 32'h0a);
    check("lda_wr", 32'(mask(B_WR)), 32'h00);

    collect(STO, 1'b1);
    check("sto_datactl", 32'(mask(B_DAT)), 32'h70);
    check("sto_wr", 32'(mask(B_WR)), 32'h40);
    check("sto_rd", 32'(mask(B_RD)), 32'h03);

    collect(SKZ, 1'b1);
    check("skz1_inc_pc", 32'(mask(B_INC)), 32'haa);
    collect(SKZ, 1'b0);
    check("skz0_inc_pc", 32'(mask(B_INC)), 32'h0a);

    collect(JMP, 1'b0);
    check("jmp_load_pc", 32'(mask(B_LPC)), 32'h30);
    check("jmp_inc_pc", 32'(mask(B_INC)), 32'h2a);

    collect(HLT, 1'b0);
    check("hlt_halt", 32'(mask(B_HLT)), 32'h08);
    check("hlt_inc_pc", 32'(mask(B_INC)), 32'h0a);

    // Asynchronous reset in the middle of slot 5 of an ADD
    opcode = ADD;
    wait_state(3'd5);
    #2 rst = 1'b1;
    #1 check("async_rst_now", 32'({state, dut_vec}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_state", 32'(state), 32'd1);
    check("post_rst_fetch", 32'(dut_vec), 32'h030);

    // ena dropped at slot 4 for three clocks
    wait_state(3'd4);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ena_low_park", 32'({state, dut_vec}), 32'd0);
    end
    ena = 1'b1;
    @(negedge clk);
    check("ena_resume_state", 32'(state), 32'd1);
    check("ena_resume_fetch", 32'(dut_vec), 32'h030);

    // Randomized run against the reference
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      zero = 1'($urandom);
      if (state == 3'd0 || state == 3'd1) opcode = 3'($urandom);
      ena = ($urandom_range(0, 15) != 0);
    end

    @(negedge clk);
    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
